output_streamer: RTL

OUTPUT_STREAMER -- requirements
Module: output_streamer

---
 rtl/output_streamer_pkg.sv | 15 +
 rtl/ack_sync.sv | 27 ++
 rtl/output_streamer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/output_streamer_pkg.sv
// Shared constants and FSM encoding for the neuron result streamer.
package output_streamer_pkg;

    localparam int unsigned NUM_OUT_DEFAULT = 4;
    localparam int unsigned WIDTH_DEFAULT   = 8;
    localparam int unsigned CHK_WIDTH       = WIDTH_DEFAULT;

    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'd0;
    localparam state_t StPresent = 2'd1;
    localparam state_t StWaitLow = 2'd2;
    localparam state_t StFinish  = 2'd3;

endpackage

// File: rtl/ack_sync.sv
// Two-flop synchronizer for an asynchronous pad strobe plus a rising-edge detector.
module ack_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/output_streamer.sv
// Snapshots perceptron results on capture and streams them, plus an XOR checksum byte,
// to a host over a four-phase ack handshake.
module output_streamer
    import output_streamer_pkg::*;
#(
    parameter int unsigned NUM_OUT = NUM_OUT_DEFAULT,
    parameter int unsigned WIDTH   = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic [WIDTH-1:0] neuron0_output,
    input  logic [WIDTH-1:0] neuron1_output,
    input  logic [WIDTH-1:0] neuron2_output,
    input  logic [WIDTH-1:0] neuron3_output,
    input  logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic [2:0]       index,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NUM_IN   = 4;
    localparam logic [2:0]  LAST_IDX = 3'(NUM_OUT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] live [NUM_IN];
    logic [WIDTH-1:0] live_ext [NUM_OUT];
    logic [WIDTH-1:0] snap_q [NUM_OUT];
    logic [WIDTH-1:0] checksum;
    logic [WIDTH-1:0] next_byte;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [2:0]       index_q, index_d;
    logic             chk_acked_q, chk_acked_d;
    logic             snap_en;
    logic             ack_level, ack_rise;

    ack_sync u_ack_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ack),
        .level    (ack_level),
        .rise     (ack_rise)
    );

    assign live[0] = neuron0_output;
    assign live[1] = neuron1_output;
    assign live[2] = neuron2_output;
    assign live[3] = neuron3_output;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_live
        if (g < NUM_IN) begin : g_in
            assign live_ext[g] = live[g];
        end else begin : g_zero
            assign live_ext[g] = '0;
        end
    end

    // Checksum comes from the snapshot so live inputs cannot disturb a frame in flight.
    always_comb begin
        checksum = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            checksum = checksum ^ snap_q[i];
        end
    end

    always_comb begin
        next_byte = checksum;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (index_q == 3'(i)) next_byte = snap_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        valid_d     = valid_q;
        data_d      = data_q;
        chk_acked_d = chk_acked_q;
        snap_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    snap_en     = 1'b1;
                    index_d     = '0;
                    valid_d     = 1'b1;
                    data_d      = live_ext[0];
                    chk_acked_d = 1'b0;
                    state_d     = StPresent;
                end
            end
            StPresent: begin
                if (ack_rise) begin
                    valid_d = 1'b0;
                    state_d = StWaitLow;
                    // Index saturates at the checksum slot; a flag marks the final ack.
                    if (index_q == LAST_IDX) chk_acked_d = 1'b1;
                    else                     index_d     = index_q + 3'd1;
                end
            end
            StWaitLow: begin
                if (!ack_level) begin
                    if (chk_acked_q) begin
                        state_d = StFinish;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = next_byte;
                        state_d = StPresent;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            index_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            chk_acked_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            chk_acked_q <= chk_acked_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) snap_q[i] <= '0;
        end else if (snap_en) begin
            for (int i = 0; i < NUM_OUT; i++) snap_q[i] <= live_ext[i];
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign index    = index_q;
    assign busy     = (state_q == StPresent) || (state_q == StWaitLow);
    assign done     = (state_q == StFinish);

endmodule
